// File: rtl/mod12_count_checker.sv
// mod12_count_checker
//   Receive-side monitor for an enable-driven modulo-MOD counter. It tracks the
//   observed count bus and checks that each edge either holds the value or
//   advances it by one (mod MOD), depending on the enable that was presented at
//   the previous edge. It locks onto a consistent stream, flags and counts
//   sequence errors, and pulses on every legal wrap from MOD-1 to 0.
//
//   Timing relationship with the observed counter:
//     - At edge k the counter updates using in_en.
//     - At edge k the checker stores in_en (en_q) and count_in (prev_q).
//     - At edge k+1 the checker compares the new count_in against prev_q,
//       expecting prev_q+1 (mod MOD) if en_q was set, or prev_q otherwise.
//   All outputs are registered, so they appear the cycle after the edge that
//   decided them.

module mod12_count_checker #(
  parameter int MOD      = 12,
  parameter int WIDTH    = 4,
  parameter int SYNC_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count
);

  // Width of the good-transition counter; it only needs to reach SYNC_LEN-1.
  localparam int GC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

  // Largest legal count value, and the modulus widened by one bit so the
  // range check stays correct even when MOD == 2**WIDTH.
  localparam logic [WIDTH-1:0] MOD_M1   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_X    = (WIDTH + 1)'(MOD);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(SYNC_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Successor of a count value in the modulo-MOD sequence.
  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v);
    return (v == MOD_M1) ? '0 : v + WIDTH'(1);
  endfunction

  // Saturating increment for the error counter: sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Registered state
  state_t           state_q,      state_d;
  logic [WIDTH-1:0] prev_q,       prev_d;
  logic             en_q,         en_d;
  logic [GC_W-1:0]  good_cnt_q,   good_cnt_d;
  logic             locked_q,     locked_d;
  logic [WIDTH-1:0] expected_q,   expected_d;
  logic             err_pulse_q,  err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0] err_count_q,  err_count_d;

  // Per-edge comparison terms
  logic             in_range;
  logic [WIDTH-1:0] want;
  logic             bad;
  logic             is_wrap;

  // Compare the sampled count against what the previous sample predicts.
  always_comb begin
    in_range = ({1'b0, count_in} < MOD_X);
    want     = en_q ? next_val(prev_q) : prev_q;
    bad      = !in_range || (count_in != want);
    is_wrap  = en_q && (prev_q == MOD_M1) && (count_in == '0);
  end

  // Next-state and next-output computation for the tracking FSM.
  always_comb begin
    // Every edge re-captures the current sample and enable; on a good
    // transition this is the same value the prediction already held, and on
    // a bad one it resynchronises the tracker to the new stream position.
    state_d      = state_q;
    prev_d       = count_in;
    en_d         = in_en;
    good_cnt_d   = good_cnt_q;
    locked_d     = locked_q;
    expected_d   = in_en ? next_val(count_in) : count_in;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_count_d  = err_count_q;

    case (state_q)
      ST_IDLE: begin
        // Wait for any in-range value to use as the starting point.
        locked_d = 1'b0;
        if (in_range) begin
          state_d    = ST_SYNC;
          good_cnt_d = '0;
        end
      end

      ST_SYNC: begin
        // Errors while acquiring are silent: just restart the run.
        locked_d = 1'b0;
        if (bad) begin
          good_cnt_d = '0;
        end else if (good_cnt_q == GC_LAST) begin
          state_d    = ST_LOCKED;
          locked_d   = 1'b1;
          good_cnt_d = '0;
        end else begin
          good_cnt_d = good_cnt_q + GC_W'(1);
        end
      end

      ST_LOCKED: begin
        if (bad) begin
          // Report the break, then reacquire from the offending sample.
          // An out-of-range sample cannot seed tracking, so fall back to IDLE.
          err_pulse_d = 1'b1;
          err_count_d = sat_inc(err_count_q);
          locked_d    = 1'b0;
          good_cnt_d  = '0;
          state_d     = in_range ? ST_SYNC : ST_IDLE;
        end else begin
          locked_d     = 1'b1;
          wrap_pulse_d = is_wrap;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        locked_d   = 1'b0;
        good_cnt_d = '0;
      end
    endcase
  end

  // Register all state and outputs; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      en_q         <= 1'b0;
      good_cnt_q   <= '0;
      locked_q     <= 1'b0;
      expected_q   <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      en_q         <= en_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign expected   = expected_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_mod12_count_checker.sv
// Testbench for mod12_count_checker: scenario tasks drive a modelled mod-12
// counter (with deliberate faults) and compare the checker outputs against a
// run-length reference model of the stream.

module tb_mod12_count_checker;

  localparam int MOD      = 12;
  localparam int WIDTH    = 4;
  localparam int SYNC_LEN = 3;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_en;
  logic [WIDTH-1:0] count_in;
  logic             locked;
  logic [WIDTH-1:0] expected;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;

  mod12_count_checker #(
    .MOD(MOD), .WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .count_in(count_in),
    .locked(locked), .expected(expected), .err_pulse(err_pulse),
    .wrap_pulse(wrap_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ctr      = 0;   // observed-counter model value presented next

  // Reference model: tracking flag plus length of the current run of good
  // transitions; lock means the run has reached SYNC_LEN.
  bit m_trk    = 0;
  int m_run    = 0;
  int m_prev   = 0;
  bit m_pen    = 0;
  bit m_locked = 0;
  bit m_errp   = 0;
  bit m_wrapp  = 0;
  int m_exp    = 0;
  int m_errc   = 0;

  // Present one edge's inputs (called at negedge), advance the model, and
  // return at the following negedge where outputs are sampled.
  task automatic step(input bit r, input bit e, input int c);
    bit in_rng, was_lock, good;
    int want;
    rst_n    = r;
    in_en    = e;
    count_in = c[WIDTH-1:0];
    if (!r) begin
      m_trk = 0; m_run = 0; m_prev = 0; m_pen = 0;
      m_locked = 0; m_errp = 0; m_wrapp = 0; m_exp = 0; m_errc = 0;
    end else begin
      in_rng   = (c < MOD);
      was_lock = m_trk && (m_run >= SYNC_LEN);
      want     = m_pen ? (m_prev + 1) % MOD : m_prev;
      good     = m_trk && in_rng && (c == want);
      m_errp   = was_lock && !good;
      m_wrapp  = was_lock && good && m_pen && (m_prev == MOD - 1) && (c == 0);
      if (m_errp && m_errc < ERR_MAX) m_errc++;
      if (!in_rng) begin
        m_trk = 0; m_run = 0;
      end else if (!m_trk) begin
        m_trk = 1; m_run = 0;
      end else if (good) begin
        if (m_run < SYNC_LEN) m_run++;
      end else begin
        m_run = 0;
      end
      m_locked = m_trk && (m_run >= SYNC_LEN);
      m_exp    = e ? (c + 1) % MOD : c;
      m_prev   = c;
      m_pen    = e;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One legal counter edge with the given enable.
  task automatic cnt_step(input bit e);
    step(1'b1, e, ctr);
    if (e) ctr = (ctr + 1) % MOD;
  endtask

  task automatic ensure_lock();
    for (int i = 0; i < 20 && !m_locked; i++) cnt_step(1'b1);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 5);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b want=0", locked); end
    checks++; if (expected !== '0) begin failures++; $display("FAIL reset_expected got=%0d want=0", expected); end
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%0b want=0", err_pulse); end
    checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL reset_wrap_pulse got=%0b want=0", wrap_pulse); end
    checks++; if (err_count !== '0) begin failures++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
  endtask

  task automatic test_free_run();
    int wraps = 0;
    ctr = 0;
    for (int i = 1; i <= 30; i++) begin
      cnt_step(1'b1);
      if (wrap_pulse === 1'b1) wraps++;
      if (i == 3) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL free_run_early_lock got=%0b want=0", locked); end
      end
      if (i == 4) begin
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL free_run_lock_edge4 got=%0b want=1", locked); end
      end
      checks++; if (locked !== m_locked) begin failures++; $display("FAIL free_run_locked cyc=%0d got=%0b want=%0b", i, locked, m_locked); end
      checks++; if (wrap_pulse !== m_wrapp) begin failures++; $display("FAIL free_run_wrap cyc=%0d got=%0b want=%0b", i, wrap_pulse, m_wrapp); end
      checks++; if (err_count !== '0) begin failures++; $display("FAIL free_run_err_count cyc=%0d got=%0d want=0", i, err_count); end
      if (m_locked) begin
        checks++; if (expected !== WIDTH'(m_exp)) begin failures++; $display("FAIL free_run_expected cyc=%0d got=%0d want=%0d", i, expected, m_exp); end
      end
    end
    checks++; if (wraps != 2) begin failures++; $display("FAIL free_run_wrap_total got=%0d want=2", wraps); end
  endtask

  task automatic test_skip();
    ensure_lock();
    for (int i = 0; i < 12 && ctr != 5; i++) cnt_step(1'b1);
    cnt_step(1'b1);          // 5 presented
    step(1'b1, 1'b1, 7);     // skip 6
    ctr = 8;
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL skip_err_pulse got=%0b want=1", err_pulse); end
    checks++; if (err_count !== ERR_W'(1)) begin failures++; $display("FAIL skip_err_count got=%0d want=1", err_count); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL skip_unlock got=%0b want=0", locked); end
    for (int i = 1; i <= 3; i++) begin
      cnt_step(1'b1);
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL skip_pulse_width step=%0d got=%0b want=0", i, err_pulse); end
      checks++; if (locked !== (i == 3)) begin failures++; $display("FAIL skip_relock step=%0d got=%0b want=%0b", i, locked, (i == 3)); end
    end
  endtask

  task automatic test_enable_toggle();
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ensure_lock();
    for (int i = 0; i < 12 && ctr != 3; i++) cnt_step(1'b1);
    for (int i = 0; i < 5; i++) begin
      cnt_step(pat[i]);
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL toggle_err step=%0d got=%0b want=0", i, err_pulse); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL toggle_locked step=%0d got=%0b want=1", i, locked); end
      checks++; if (expected !== WIDTH'(m_exp)) begin failures++; $display("FAIL toggle_expected step=%0d got=%0d want=%0d", i, expected, m_exp); end
    end
  endtask

  task automatic test_hold();
    ensure_lock();
    for (int i = 0; i < 20; i++) begin
      cnt_step(1'b0);
      checks++; if (locked !== 1'b1 || err_pulse !== 1'b0) begin failures++; $display("FAIL hold cyc=%0d locked=%0b err_pulse=%0b want locked=1 err_pulse=0", i, locked, err_pulse); end
    end
  endtask

  task automatic test_out_of_range();
    int base;
    ensure_lock();
    base = m_errc;
    step(1'b1, 1'b1, 13);
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL oor_err_pulse got=%0b want=1", err_pulse); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL oor_unlock got=%0b want=0", locked); end
    checks++; if (err_count !== ERR_W'(base + 1)) begin failures++; $display("FAIL oor_err_count got=%0d want=%0d", err_count, base + 1); end
    for (int i = 1; i <= 4; i++) begin
      cnt_step(1'b1);
      checks++; if (locked !== (i == 4)) begin failures++; $display("FAIL oor_relock edge=%0d got=%0b want=%0b", i, locked, (i == 4)); end
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL oor_no_err edge=%0d got=%0b want=0", i, err_pulse); end
    end
  endtask

  task automatic test_random();
    bit e;
    int c;
    for (int i = 0; i < 300; i++) begin
      e = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        c = $urandom_range(0, 15);
        step(1'b1, e, c);
        if (c < MOD) ctr = e ? (c + 1) % MOD : c;
      end else begin
        cnt_step(e);
      end
      checks++; if (locked !== m_locked) begin failures++; $display("FAIL rand_locked cyc=%0d got=%0b want=%0b", i, locked, m_locked); end
      checks++; if (err_pulse !== m_errp) begin failures++; $display("FAIL rand_err_pulse cyc=%0d got=%0b want=%0b", i, err_pulse, m_errp); end
      checks++; if (wrap_pulse !== m_wrapp) begin failures++; $display("FAIL rand_wrap cyc=%0d got=%0b want=%0b", i, wrap_pulse, m_wrapp); end
      checks++; if (err_count !== ERR_W'(m_errc)) begin failures++; $display("FAIL rand_err_count cyc=%0d got=%0d want=%0d", i, err_count, m_errc); end
      if (m_locked) begin
        checks++; if (expected !== WIDTH'(m_exp)) begin failures++; $display("FAIL rand_expected cyc=%0d got=%0d want=%0d", i, expected, m_exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    ensure_lock();
    for (int i = 0; i < 12 && ctr != 9; i++) cnt_step(1'b1);
    step(1'b0, 1'b1, ctr);
    ctr = (ctr + 1) % MOD;
    checks++; if (locked !== 1'b0 || expected !== '0 || err_pulse !== 1'b0 || wrap_pulse !== 1'b0 || err_count !== '0) begin
      failures++; $display("FAIL midreset_outputs locked=%0b expected=%0d err_pulse=%0b wrap=%0b err_count=%0d want all 0", locked, expected, err_pulse, wrap_pulse, err_count);
    end
    for (int i = 1; i <= 4; i++) begin
      cnt_step(1'b1);
      checks++; if (locked !== (i == 4)) begin failures++; $display("FAIL midreset_relock edge=%0d got=%0b want=%0b", i, locked, (i == 4)); end
    end
  endtask

  task automatic test_saturation();
    int c;
    ensure_lock();
    for (int n = 0; n < 300; n++) begin
      c = (ctr + 2) % MOD;
      step(1'b1, 1'b1, c);
      ctr = (c + 1) % MOD;
      checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL sat_err_pulse n=%0d got=%0b want=1", n, err_pulse); end
      checks++; if (err_count !== ERR_W'(m_errc)) begin failures++; $display("FAIL sat_err_count n=%0d got=%0d want=%0d", n, err_count, m_errc); end
      for (int k = 0; k < SYNC_LEN; k++) cnt_step(1'b1);
    end
    checks++; if (err_count !== ERR_W'(ERR_MAX)) begin failures++; $display("FAIL sat_final got=%0d want=%0d", err_count, ERR_MAX); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_skip();
    test_enable_toggle();
    test_hold();
    test_out_of_range();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
